// File: rtl/pipe_addsub_hs.sv
// pipe_addsub_hs: WIDTH-bit add/sub split into SEG-bit pipeline stages; in_valid/in_ready/a/b/c_in/sub in, out_valid/out_ready/sum/c_out/overflow out, flush drops in-flight beats
module pipe_addsub_hs #(
  parameter int WIDTH = 32,
  parameter int SEG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int STAGES = WIDTH / SEG;
  localparam int L = STAGES - 1;
  logic [STAGES-1:0] v, cy, rdy, sv, sc;
  logic [STAGES-1:0][WIDTH-1:0] ra, rb, rs, sa, sb, sr, nrs;
  logic [STAGES-1:0][SEG:0] sl;
  logic ovf, nov, chain;
  always_comb begin
    sa[0] = a;
    sb[0] = sub ? ~b : b;
    sc[0] = sub | c_in;
    sr[0] = '0;
    sv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      sa[k] = ra[k-1];
      sb[k] = rb[k-1];
      sc[k] = cy[k-1];
      sr[k] = rs[k-1];
      sv[k] = v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl[k] = {1'b0, sa[k][k*SEG +: SEG]} + {1'b0, sb[k][k*SEG +: SEG]} + {{SEG{1'b0}}, sc[k]};
      nrs[k] = sr[k] | (WIDTH'(sl[k][SEG-1:0]) << (k*SEG));
    end
    nov = sa[L][WIDTH-1] ^ sb[L][WIDTH-1] ^ sl[L][SEG-1] ^ sl[L][SEG];
  end
  always_comb begin
    chain = out_ready;
    rdy = '0;
    for (int k = L; k >= 0; k--) begin
      chain = ~v[k] | chain;
      rdy[k] = chain;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      cy <= '0;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      ovf <= 1'b0;
    end else begin
      v <= flush ? '0 : (rdy & sv) | (~rdy & v);
      for (int k = 0; k < STAGES; k++)
        if (rdy[k]) begin
          ra[k] <= sa[k];
          rb[k] <= sb[k];
          rs[k] <= nrs[k];
          cy[k] <= sl[k][SEG];
        end
      if (rdy[L]) ovf <= nov;
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = v[L];
  assign sum = rs[L];
  assign c_out = cy[L];
  assign overflow = ovf;
endmodule

// File: tb/tb_pipe_addsub_hs.sv
// tb_pipe_addsub_hs: randomized self-checking bench against an arithmetic/queue reference model
module tb_pipe_addsub_hs;
  localparam int STAGES = 4;
  localparam int L = STAGES - 1;
  localparam longint MAXS = (longint'(1) <<< 31) - 1;
  localparam longint MINS = -(longint'(1) <<< 31);
  logic clk = 1'b0, rst, in_valid, in_ready, c_in, sub, flush, out_valid, out_ready, c_out, overflow;
  logic [31:0] a, b, sum;
  int n_chk = 0, n_fail = 0, n_out = 0;
  logic mon_on = 1'b0;
  typedef struct { logic [31:0] s; logic c; logic o; int p; } item_t;
  item_t q[$];
  pipe_addsub_hs #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic item_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    item_t it;
    longint ux = longint'(x), uy = longint'(y), sx = longint'($signed(x)), sy = longint'($signed(y));
    longint c0 = ci ? 1 : 0;
    longint r = sb ? sx - sy : sx + sy + c0;
    it.s = r[31:0];
    it.o = (r > MAXS) || (r < MINS);
    it.c = sb ? (ux >= uy) : ((ux + uy + c0) > 64'hFFFF_FFFF);
    it.p = 0;
    return it;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (mon_on) begin
    logic exp_ir, exp_ov;
    int lim;
    bit popped;
    exp_ir = (q.size() < STAGES) || out_ready;
    exp_ov = (q.size() > 0) && (q[0].p == L);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (out_valid && q.size() > 0) begin
      chk("sum", sum, q[0].s);
      chk("c_out", c_out, q[0].c);
      chk("overflow", overflow, q[0].o);
    end
    if (rst || flush) q.delete();
    else begin
      lim = STAGES;
      popped = 0;
      for (int i = 0; i < q.size(); i++) begin
        if (i == 0 && q[0].p == L && out_ready) popped = 1;
        else begin
          q[i].p = (q[i].p + 1 > lim - 1) ? lim - 1 : q[i].p + 1;
          lim = q[i].p;
        end
      end
      if (popped) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_valid && exp_ir) q.push_back(model(a, b, c_in, sub));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_beat();
    a = $urandom;
    b = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
    c_in = 1'($urandom_range(1));
    sub = 1'($urandom_range(1));
  endtask
  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic one_beat(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts,
                          input logic [31:0] es, input logic ec, input logic eo);
    a = ta;
    b = tb_;
    c_in = tc;
    sub = ts;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (STAGES - 2) tick();
    chk("lat_early_valid", out_valid, 1'b0);
    tick();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_sum", sum, es);
    chk("lat_c_out", c_out, ec);
    chk("lat_overflow", overflow, eo);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    item_t r;
    int acc, n0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    sub = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    mon_on = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    r = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_add", {r.s, r.c, r.o}, {32'h0, 1'b1, 1'b0});
    r = model(32'h5, 32'h7, 1'b1, 1'b1);
    chk("pin_sub_borrow", {r.s, r.c, r.o}, {32'hFFFF_FFFE, 1'b0, 1'b0});
    r = model(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("pin_sub_ovf", {r.s, r.c, r.o}, {32'h7FFF_FFFF, 1'b1, 1'b1});
    r = model(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk("pin_add_cin_ovf", {r.s, r.c, r.o}, {32'h8000_0000, 1'b0, 1'b1});
    rst = 1'b0;
    one_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    one_beat(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one_beat(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      rnd_beat();
      in_valid = 1'b1;
      tick();
    end
    drain();
    chk("stream_count", n_out - n0, 100);
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    repeat (10) begin
      rnd_beat();
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", in_ready, 1'b0);
    n0 = n_out;
    out_ready = 1'b1;
    repeat (10) begin
      rnd_beat();
      tick();
    end
    drain();
    chk("bp_out_count", n_out - n0, 14);
    repeat (3) begin
      rnd_beat();
      in_valid = 1'b1;
      tick();
    end
    rnd_beat();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_model_empty", q.size(), 0);
    repeat (6) tick();
    for (int i = 0; i < 300; i++) begin
      rnd_beat();
      in_valid = 1'($urandom_range(3) != 0);
      out_ready = 1'($urandom_range(3) != 0);
      flush = ($urandom_range(31) == 0);
      tick();
    end
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rnd_beat();
      in_valid = 1'b1;
      out_ready = (i < 5) ? 1'b0 : 1'($urandom_range(1));
      tick();
    end
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 32'h0);
    chk("mid_rst_c_out", c_out, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    one_beat(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_addsub_hs.md
# pipe_addsub_hs

Parametrised, segmented pipelined adder/subtractor with a valid/ready handshake on both sides. Each stage adds one SEG-bit slice and registers the carry forward, as the stall-capable 32-bit pipelined adder does. This block generalises that adder in width and depth and adds:
- subtract mode
- per-stage backpressure in place of a global stop
- flush
- signed-overflow flag

It sits between operand sources and consumers in the lab datapath wherever a long carry chain must be split across cycles.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG, STAGES ≥ 1.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in; used only when sub=0.
- sub  in  1  1 selects a − b; 0 selects a + b + c_in.
- flush  in  1  drop all in-flight beats.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer takes the result this cycle.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of bit WIDTH−1. In subtract mode 1 = no borrow.
- overflow  out  1  two's-complement signed overflow of the result.

## Operation
- Operand preparation at input:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : c_in
- Stage k (0..STAGES−1) holds four fields:
  - v_k: valid bit.
  - carry_k: carry out of slice k.
  - Accumulated result bits [SEG·(k+1)−1:0].
  - Remaining unadded upper operand slices of a and b_eff.
- Stage 0 adds a[SEG−1:0] + b_eff[SEG−1:0] + cin_eff.
- Stage k>0 adds slice k of the carried operands + carry_{k−1}, and appends the result slice above the lower result bits.
- Overflow is computed in the last stage from the top slice: carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Outputs are direct from the last stage registers:
  - out_valid = v_{STAGES−1}
  - sum, c_out and overflow are driven from the last stage's registered fields.
- Handshake: ready_k = ~v_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0 (combinational chain).
- Stage k loads from stage k−1 (or from the inputs for k=0) when ready_k=1. The loaded v_k is v_{k−1} (or in_valid).
- When ready_k=0, stage k holds all fields unchanged. This gives full throughput of one beat per cycle with no bubbles under continuous out_ready.
- Data fields of a stage loading an invalid beat are don't-care. The bench checks sum, c_out and overflow only when out_valid=1.
- A beat transfers in when in_valid & in_ready; out when out_valid & out_ready.
- Flush: all v_k cleared next edge.
  - flush has priority over input acceptance; a beat offered in the same cycle is dropped.
  - Data fields may update; they are not cleared.
- Arithmetic is modulo 2^WIDTH; sum = (a ± b [+ c_in]) mod 2^WIDTH.

## Timing
- Reset: all v_k = 0; all data, carry and overflow registers = 0. After reset: out_valid=0, sum=0, c_out=0, overflow=0, in_ready=1.
- rst has priority over flush and handshake; asserting rst mid-stream discards all beats at the next edge.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles from the in_valid cycle, when no stall occurs.
- Stall: out_ready=0 with out_valid=1 holds the last stage. Upstream stages keep filling until every stage is valid; then in_ready=0 in the same cycle.
- Capacity is STAGES beats. Releasing out_ready drains one beat per cycle, with in_ready=1 in that same cycle (simultaneous in/out allowed).
- Order is strictly preserved; no beat is lost or duplicated except by flush or rst.

## Test plan
- WIDTH=32, SEG=8: a=0xFFFF_FFFF, b=0x0000_0001, c_in=0, sub=0 → after 4 cycles sum=0x0000_0000, c_out=1, overflow=0.
- sub=1, a=0x0000_0005, b=0x0000_0007 → sum=0xFFFF_FFFE, c_out=0 (borrow), overflow=0. Same with a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, c_out=1, overflow=1.
- Streaming: 100 random beats back-to-back with out_ready=1 → one result per cycle, in order, all matching the reference model, no gaps after the initial 4-cycle fill.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 → exactly 4 beats accepted, then in_ready=0. Release → 4 results in order, then streaming resumes.
- flush asserted with 3 beats in flight, plus a new beat offered in the same cycle → next cycle out_valid=0 and all stages empty. No flushed result is ever emitted.
- rst asserted mid-stream with stalls → next cycle all outputs at reset values. First beat after deassert emerges after exactly 4 cycles.
